asym_reg_addr_2tdp_ram: RTL and testbench



---
 rtl/asym_reg_addr_2tdp_ram.sv | 106 ++++++++++
 tb/tb_asym_reg_addr_2tdp_ram.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/asym_reg_addr_2tdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : asym_reg_addr_2tdp_ram
// Brief    : Two true-dual-port RAMs (RAM1 256x8, RAM2 1024x16) with
//            registered read addresses and combinational write-first reads.
//            Port B wins a same-address write collision. Reset clears the
//            address registers and read-valid flags and blocks writes on
//            that edge; memory contents are kept.
// Config   : ASYM_RAM_INIT_ZERO_EN - when defined, both arrays start at 0.
// Revision : 1.0 - initial release
// ============================================================================
module asym_reg_addr_2tdp_ram (
   input  logic        clkA,
   input  logic        rst,
   input  logic        clkB,
   // RAM1 ports
   input  logic        weA,
   input  logic        weB,
   input  logic [7:0]  addrA,
   input  logic [7:0]  addrB,
   input  logic [7:0]  dinA,
   input  logic [7:0]  dinB,
   output logic [7:0]  doutA,
   output logic [7:0]  doutB,
   // RAM2 ports
   input  logic        weA1,
   input  logic        weB1,
   input  logic [9:0]  addrA1,
   input  logic [9:0]  addrB1,
   input  logic [15:0] dinA1,
   input  logic [15:0] dinB1,
   output logic [15:0] doutA1,
   output logic [15:0] doutB1
);

   localparam int c_DEPTH1 = 256;
   localparam int c_DEPTH2 = 1024;

   // clkB exists only for pin compatibility; everything runs on clkA
   logic w_unusedClkB;
   assign w_unusedClkB = clkB;

`ifdef ASYM_RAM_INIT_ZERO_EN
   logic [7:0]  r_mem1 [c_DEPTH1] = '{default: '0};
   logic [15:0] r_mem2 [c_DEPTH2] = '{default: '0};
`else
   logic [7:0]  r_mem1 [c_DEPTH1];
   logic [15:0] r_mem2 [c_DEPTH2];
`endif

   logic [7:0] r_addrA;
   logic [7:0] r_addrB;
   logic [9:0] r_addrA1;
   logic [9:0] r_addrB1;
   logic       r_validA;
   logic       r_validB;
   logic       r_validA1;
   logic       r_validB1;

   // RAM1 writes; port B is assigned last so it wins an address collision
   always_ff @(posedge clkA) begin
      if (!rst) begin
         if (weA) r_mem1[addrA] <= dinA;
         if (weB) r_mem1[addrB] <= dinB;
      end
   end

   // RAM2 writes; port B is assigned last so it wins an address collision
   always_ff @(posedge clkA) begin
      if (!rst) begin
         if (weA1) r_mem2[addrA1] <= dinA1;
         if (weB1) r_mem2[addrB1] <= dinB1;
      end
   end

   // Read address registers and read-valid flags for all four ports
   always_ff @(posedge clkA) begin
      if (rst) begin
         r_addrA   <= '0;
         r_addrB   <= '0;
         r_addrA1  <= '0;
         r_addrB1  <= '0;
         r_validA  <= 1'b0;
         r_validB  <= 1'b0;
         r_validA1 <= 1'b0;
         r_validB1 <= 1'b0;
      end else begin
         r_addrA   <= addrA;
         r_addrB   <= addrB;
         r_addrA1  <= addrA1;
         r_addrB1  <= addrB1;
         r_validA  <= 1'b1;
         r_validB  <= 1'b1;
         r_validA1 <= 1'b1;
         r_validB1 <= 1'b1;
      end
   end

   // Reads look at live storage, so a write to the held address shows at once
   assign doutA  = r_validA  ? r_mem1[r_addrA]  : '0;
   assign doutB  = r_validB  ? r_mem1[r_addrB]  : '0;
   assign doutA1 = r_validA1 ? r_mem2[r_addrA1] : '0;
   assign doutB1 = r_validB1 ? r_mem2[r_addrB1] : '0;

endmodule
`default_nettype wire

// File: tb/tb_asym_reg_addr_2tdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_asym_reg_addr_2tdp_ram
// Brief    : Self-checking bench for asym_reg_addr_2tdp_ram with a
//            behavioural memory model and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_asym_reg_addr_2tdp_ram;

   logic        clkA, clkB, rst;
   logic        weA, weB, weA1, weB1;
   logic [7:0]  addrA, addrB, dinA, dinB, doutA, doutB;
   logic [9:0]  addrA1, addrB1;
   logic [15:0] dinA1, dinB1, doutA1, doutB1;

   int checks = 0;
   int errors = 0;

   // Reference model: plain arrays plus the address each port last presented
   logic [7:0]  m1 [256];
   logic [15:0] m2 [1024];
   logic [7:0]  mAddrA, mAddrB;
   logic [9:0]  mAddrA1, mAddrB1;
   bit          mValid = 1'b0;

   asym_reg_addr_2tdp_ram dut (
      .clkA(clkA), .rst(rst), .clkB(clkB),
      .weA(weA), .weB(weB), .addrA(addrA), .addrB(addrB),
      .dinA(dinA), .dinB(dinB), .doutA(doutA), .doutB(doutB),
      .weA1(weA1), .weB1(weB1), .addrA1(addrA1), .addrB1(addrB1),
      .dinA1(dinA1), .dinB1(dinB1), .doutA1(doutA1), .doutB1(doutB1)
   );

   initial begin
      clkA = 1'b0;
      forever #5 clkA = ~clkA;
   end
   assign clkB = clkA;

   function automatic logic [7:0] expA();
      return mValid ? m1[mAddrA] : 8'h00;
   endfunction
   function automatic logic [7:0] expB();
      return mValid ? m1[mAddrB] : 8'h00;
   endfunction
   function automatic logic [15:0] expA1();
      return mValid ? m2[mAddrA1] : 16'h0000;
   endfunction
   function automatic logic [15:0] expB1();
      return mValid ? m2[mAddrB1] : 16'h0000;
   endfunction

   task automatic idleInputs();
      weA = 0; weB = 0; weA1 = 0; weB1 = 0;
      addrA = 0; addrB = 0; addrA1 = 0; addrB1 = 0;
      dinA = 0; dinB = 0; dinA1 = 0; dinB1 = 0;
   endtask

   // One clock edge: update the model from the applied inputs, settle outputs
   task automatic tick();
      @(posedge clkA);
      if (rst) begin
         mValid = 1'b0;
         mAddrA = 0; mAddrB = 0; mAddrA1 = 0; mAddrB1 = 0;
      end else begin
         if (weA)  m1[addrA]  = dinA;
         if (weB)  m1[addrB]  = dinB;
         if (weA1) m2[addrA1] = dinA1;
         if (weB1) m2[addrB1] = dinB1;
         mAddrA = addrA; mAddrB = addrB; mAddrA1 = addrA1; mAddrB1 = addrB1;
         mValid = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idleInputs();
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (doutA !== 8'h00) begin errors++; $display("FAIL reset_doutA: got %h want 00", doutA); end
         checks++; if (doutB !== 8'h00) begin errors++; $display("FAIL reset_doutB: got %h want 00", doutB); end
         checks++; if (doutA1 !== 16'h0000) begin errors++; $display("FAIL reset_doutA1: got %h want 0000", doutA1); end
         checks++; if (doutB1 !== 16'h0000) begin errors++; $display("FAIL reset_doutB1: got %h want 0000", doutB1); end
      end
      rst = 1'b0;
      #1;
      checks++; if (doutA !== 8'h00 || doutB !== 8'h00 || doutA1 !== 16'h0000 || doutB1 !== 16'h0000) begin
         errors++; $display("FAIL release_before_edge: got %h %h %h %h want all 0", doutA, doutB, doutA1, doutB1);
      end
   endtask

   // Write every location once so later reads have known contents
   task automatic test_fill();
      for (int i = 0; i < 512; i++) begin
         weA = (i < 128); weB = (i < 128);
         addrA = 8'(i % 128); addrB = 8'(128 + (i % 128));
         dinA = 8'($urandom); dinB = 8'($urandom);
         weA1 = 1; weB1 = 1;
         addrA1 = 10'(i); addrB1 = 10'(512 + i);
         dinA1 = 16'($urandom); dinB1 = 16'($urandom);
         tick();
         checks++; if (doutA !== expA() || doutB !== expB() || doutA1 !== expA1() || doutB1 !== expB1()) begin
            errors++; $display("FAIL fill_%0d: got %h %h %h %h want %h %h %h %h", i,
               doutA, doutB, doutA1, doutB1, expA(), expB(), expA1(), expB1());
         end
      end
      idleInputs();
   endtask

   task automatic test_ram1_basic();
      weA = 1; addrA = 8'h10; dinA = 8'h5A;
      weB = 1; addrB = 8'h80; dinB = 8'hC3;
      tick();
      checks++; if (doutA !== 8'h5A) begin errors++; $display("FAIL wr_first_A: got %h want 5a", doutA); end
      weA = 0; weB = 0; addrA = 8'h33; addrB = 8'hF0;
      tick();
      addrA = 8'h10; addrB = 8'h80;
      tick();
      checks++; if (doutA !== 8'h5A) begin errors++; $display("FAIL ram1_rd_A: got %h want 5a", doutA); end
      checks++; if (doutB !== 8'hC3) begin errors++; $display("FAIL ram1_rd_B: got %h want c3", doutB); end
      tick();
      checks++; if (doutA !== 8'h5A) begin errors++; $display("FAIL ram1_hold_A: got %h want 5a", doutA); end
      idleInputs();
   endtask

   task automatic test_ram2_cross();
      weA1 = 1; addrA1 = 10'h1FF; dinA1 = 16'hBEEF; addrB1 = 10'h000;
      tick();
      weA1 = 0; addrB1 = 10'h1FF;
      tick();
      checks++; if (doutB1 !== 16'hBEEF) begin errors++; $display("FAIL cross_B1: got %h want beef", doutB1); end
      weB1 = 1; addrB1 = 10'h3FF; dinB1 = 16'h1234; addrA1 = 10'h000;
      tick();
      weB1 = 0; addrA1 = 10'h3FF; addrB1 = 10'h1FF;
      tick();
      checks++; if (doutA1 !== 16'h1234) begin errors++; $display("FAIL cross_A1: got %h want 1234", doutA1); end
      // B holds 0x1FF while A overwrites it: B must show the new word
      weA1 = 1; addrA1 = 10'h1FF; dinA1 = 16'h5555;
      tick();
      checks++; if (doutB1 !== 16'h5555) begin errors++; $display("FAIL cross_live_B1: got %h want 5555", doutB1); end
      idleInputs();
   endtask

   task automatic test_collision();
      weA = 1; weB = 1; addrA = 8'h42; addrB = 8'h42; dinA = 8'h11; dinB = 8'h22;
      weA1 = 1; weB1 = 1; addrA1 = 10'h100; addrB1 = 10'h100; dinA1 = 16'h1111; dinB1 = 16'h2222;
      tick();
      weA = 0; weB = 0; weA1 = 0; weB1 = 0;
      tick();
      checks++; if (doutA !== 8'h22) begin errors++; $display("FAIL coll_A: got %h want 22", doutA); end
      checks++; if (doutB !== 8'h22) begin errors++; $display("FAIL coll_B: got %h want 22", doutB); end
      checks++; if (doutA1 !== 16'h2222) begin errors++; $display("FAIL coll_A1: got %h want 2222", doutA1); end
      checks++; if (doutB1 !== 16'h2222) begin errors++; $display("FAIL coll_B1: got %h want 2222", doutB1); end
      idleInputs();
   endtask

   task automatic test_reset_mid_write();
      logic [15:0] prior;
      prior = m2[5];
      rst = 1; weA1 = 1; addrA1 = 10'h005; dinA1 = 16'hAAAA;
      tick();
      checks++; if (doutA1 !== 16'h0000) begin errors++; $display("FAIL rstwr_dout: got %h want 0000", doutA1); end
      rst = 0; weA1 = 0;
      tick();
      checks++; if (doutA1 !== prior) begin errors++; $display("FAIL rstwr_prior: got %h want %h", doutA1, prior); end
      idleInputs();
   endtask

   task automatic test_random();
      for (int i = 0; i < 1023; i++) begin
         rst  = ($urandom_range(0, 63) == 0);
         weA  = 1'($urandom); weB  = 1'($urandom);
         weA1 = 1'($urandom); weB1 = 1'($urandom);
         addrA  = 8'($urandom_range(0, 127));   addrB  = 8'($urandom_range(128, 255));
         addrA1 = 10'($urandom_range(0, 511));  addrB1 = 10'($urandom_range(512, 1023));
         dinA  = 8'($urandom);  dinB  = 8'($urandom);
         dinA1 = 16'($urandom); dinB1 = 16'($urandom);
         tick();
         checks++; if (doutA !== expA()) begin errors++; $display("FAIL rand_A_%0d: got %h want %h", i, doutA, expA()); end
         checks++; if (doutB !== expB()) begin errors++; $display("FAIL rand_B_%0d: got %h want %h", i, doutB, expB()); end
         checks++; if (doutA1 !== expA1()) begin errors++; $display("FAIL rand_A1_%0d: got %h want %h", i, doutA1, expA1()); end
         checks++; if (doutB1 !== expB1()) begin errors++; $display("FAIL rand_B1_%0d: got %h want %h", i, doutB1, expB1()); end
      end
      rst = 0;
      idleInputs();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_ram1_basic();
      test_ram2_cross();
      test_collision();
      test_reset_mid_write();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
